// File: rtl/branch_hazard_scoreboard.sv
// ID-stage hazard unit: branch/load-use stalls and ID branch forwarding selects, combinational from the stage inputs.
// Multi-cycle memory waits are held by a registered FSM with a sticky timeout flag and a saturating stall-cycle counter.
module branch_hazard_scoreboard #(
   parameter int REG_AW     = 5,
   parameter int NUM_SRC    = 2,
   parameter int LD_TIMEOUT = 16,
   parameter int CNT_W      = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        flush,
   input  logic                        id_valid,
   input  logic                        id_branch,
   input  logic [NUM_SRC-1:0]          id_src_used,
   input  logic [NUM_SRC*REG_AW-1:0]   id_src_addr,
   input  logic                        id2ex_reg_write,
   input  logic                        id2ex_mem_read,
   input  logic [REG_AW-1:0]           id2ex_wr_addr,
   input  logic                        ex2mem_reg_write,
   input  logic                        ex2mem_mem_read,
   input  logic [REG_AW-1:0]           ex2mem_wr_addr,
   input  logic                        mem_busy,
   input  logic                        mem2wb_reg_write,
   input  logic [REG_AW-1:0]           mem2wb_wr_addr,
   output logic                        stall,
   output logic                        stall_beq,
   output logic                        stall_ld,
   output logic [2*NUM_SRC-1:0]        br_fwd_sel,
   output logic                        err_timeout,
   output logic [CNT_W-1:0]            stall_count
);

   localparam int WCW = $clog2(LD_TIMEOUT) + 1;
   localparam logic [WCW-1:0] WAIT_LAST = WCW'(LD_TIMEOUT - 1);

   typedef enum logic {IDLE = 1'b0, LD_WAIT = 1'b1} state_t;

   state_t           state, state_nxt;
   logic [WCW-1:0]   wait_cnt, wait_cnt_nxt;
   logic             err_nxt;

   logic [NUM_SRC-1:0] mx, lx, mm, lm, mw;
   logic               beq_c, ld_c, wait_c, block;

   genvar g;
   for (g = 0; g < NUM_SRC; g++) begin : g_src
      logic [REG_AW-1:0] src;
      logic              act;

      assign src   = id_src_addr[g*REG_AW +: REG_AW];
      assign act   = id_valid & id_src_used[g] & (src != '0);
      assign mx[g] = act & id2ex_reg_write & (id2ex_wr_addr == src);
      assign lx[g] = mx[g] & id2ex_mem_read;
      assign mm[g] = act & ex2mem_reg_write & (ex2mem_wr_addr == src);
      assign lm[g] = mm[g] & ex2mem_mem_read;
      assign mw[g] = act & mem2wb_reg_write & (mem2wb_wr_addr == src);

      // A MEM-stage ALU result is newer than WB data, so it wins.
      assign br_fwd_sel[2*g +: 2] = (rst | !id_branch | stall) ? 2'b00 :
                                    (mm[g] & !ex2mem_mem_read) ? 2'b01 :
                                    mw[g]                      ? 2'b10 : 2'b00;
   end

   assign beq_c     = id_branch & (|(mx | lm));
   assign ld_c      = |lx;
   assign wait_c    = (state == LD_WAIT) & mem_busy;
   assign block     = rst | flush;
   assign stall_beq = beq_c & !block;
   assign stall_ld  = (ld_c | wait_c) & !block;
   assign stall     = stall_beq | stall_ld;

   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      err_nxt      = err_timeout;
      if (state == IDLE) begin
         if (ex2mem_mem_read & mem_busy & !flush) begin
            state_nxt    = LD_WAIT;
            wait_cnt_nxt = '0;
         end
      end else begin
         if (flush | !mem_busy) begin
            state_nxt = IDLE;
         end else if (wait_cnt == WAIT_LAST) begin
            // Counter parks at its last value; the error flag is sticky anyway.
            err_nxt = 1'b1;
         end else begin
            wait_cnt_nxt = wait_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         wait_cnt    <= '0;
         err_timeout <= 1'b0;
      end else begin
         state       <= state_nxt;
         wait_cnt    <= wait_cnt_nxt;
         err_timeout <= err_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_count <= '0;
      end else if (stall && (stall_count != {CNT_W{1'b1}})) begin
         stall_count <= stall_count + 1'b1;
      end
   end

endmodule
